// File: rtl/discharge_param_scheduler.sv
// discharge_param_scheduler: start/stop arbitration and safe-point commit of shadow Ton/Toff/Ip/waveform parameters.
// Optional watchdog on the stop sequence is built when SCHED_STOP_WATCHDOG_EN is defined.
module discharge_param_scheduler #(
  parameter logic [15:0] TON_MIN      = 16'd10,
  parameter logic [15:0] TOFF_MIN     = 16'd20,
  parameter logic [15:0] IP_MAX       = 16'd4000,
  parameter logic [15:0] DEF_TON      = 16'd100,
  parameter logic [15:0] DEF_TOFF     = 16'd400,
  parameter logic [15:0] DEF_IP       = 16'd0,
  parameter logic [15:0] DEF_WAVE     = 16'd0,
  parameter logic [19:0] STOP_TIMEOUT = 20'd100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        change_ton_req,
  input  logic        change_toff_req,
  input  logic        change_ip_req,
  input  logic        change_wave_req,
  input  logic [15:0] ton_in,
  input  logic [15:0] toff_in,
  input  logic [15:0] ip_in,
  input  logic [15:0] wave_in,
  input  logic        start_req_spi,
  input  logic        stop_req_spi,
  input  logic        start_req_key,
  input  logic        stop_req_key,
  input  logic        pulse_boundary,
  input  logic        gen_idle,
  output logic [15:0] ton_act,
  output logic [15:0] toff_act,
  output logic [15:0] ip_act,
  output logic [15:0] wave_act,
  output logic        commit_strobe,
  output logic        run_en,
  output logic [3:0]  pending,
  output logic        reject,
  output logic        stop_fault
);
  typedef enum logic [1:0] {STOPPED, STARTING, RUNNING, STOPPING} state_t;
  state_t state;
  logic [15:0] sh_ton, sh_toff, sh_ip, sh_wave;
  logic [3:0] req, acc, commit;
  logic start, stop, quiet, timeout;
  assign start = start_req_spi | start_req_key;
  assign stop  = stop_req_spi | stop_req_key;
  assign req   = {change_wave_req, change_ip_req, change_toff_req, change_ton_req};
  assign acc   = req & {1'b1, ip_in <= IP_MAX, toff_in >= TOFF_MIN, ton_in >= TON_MIN};
  // wave may only change while the generator is guaranteed off
  assign quiet  = (state == STOPPED) || (state == STARTING);
  assign commit = pending & {quiet, {3{quiet || (state == RUNNING && pulse_boundary)}}};
`ifdef SCHED_STOP_WATCHDOG_EN
  logic [19:0] wd_cnt, wd_nxt;
  logic fault_q;
  assign wd_nxt     = (wd_cnt == 20'hFFFFF) ? wd_cnt : wd_cnt + 20'd1;
  assign timeout    = (state == STOPPING) && !gen_idle && (wd_nxt == STOP_TIMEOUT);
  assign stop_fault = fault_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt  <= '0;
      fault_q <= 1'b0;
    end else begin
      wd_cnt  <= (state == RUNNING && stop) ? 20'd0 : (state == STOPPING) ? wd_nxt : wd_cnt;
      fault_q <= (state == STOPPED && start && !stop) ? 1'b0 : timeout ? 1'b1 : fault_q;
    end
  end
`else
  assign timeout    = 1'b0;
  assign stop_fault = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= STOPPED;
      sh_ton        <= DEF_TON;
      sh_toff       <= DEF_TOFF;
      sh_ip         <= DEF_IP;
      sh_wave       <= DEF_WAVE;
      ton_act       <= DEF_TON;
      toff_act      <= DEF_TOFF;
      ip_act        <= DEF_IP;
      wave_act      <= DEF_WAVE;
      pending       <= '0;
      commit_strobe <= 1'b0;
      reject        <= 1'b0;
      run_en        <= 1'b0;
    end else begin
      sh_ton        <= acc[0] ? ton_in : sh_ton;
      sh_toff       <= acc[1] ? toff_in : sh_toff;
      sh_ip         <= acc[2] ? ip_in : sh_ip;
      sh_wave       <= acc[3] ? wave_in : sh_wave;
      ton_act       <= commit[0] ? sh_ton : ton_act;
      toff_act      <= commit[1] ? sh_toff : toff_act;
      ip_act        <= commit[2] ? sh_ip : ip_act;
      wave_act      <= commit[3] ? sh_wave : wave_act;
      pending       <= (pending & ~commit) | acc;
      commit_strobe <= |commit;
      reject        <= |(req & ~acc);
      case (state)
        STOPPED:  if (start && !stop) state <= STARTING;
        STARTING: begin
          state  <= stop ? STOPPED : RUNNING;
          run_en <= !stop;
        end
        RUNNING:  if (stop) begin
          state  <= STOPPING;
          run_en <= 1'b0;
        end
        STOPPING: if (gen_idle || timeout) state <= STOPPED;
        default:  state <= STOPPED;
      endcase
    end
  end
endmodule

// File: tb/tb_discharge_param_scheduler.sv
// tb_discharge_param_scheduler: directed stimulus with a queue-based scoreboard on commit_strobe/reject events.
module tb_discharge_param_scheduler;
  logic clk = 0, rst_n = 0;
  logic change_ton_req = 0, change_toff_req = 0, change_ip_req = 0, change_wave_req = 0;
  logic [15:0] ton_in = 0, toff_in = 0, ip_in = 0, wave_in = 0;
  logic start_req_spi = 0, stop_req_spi = 0, start_req_key = 0, stop_req_key = 0;
  logic pulse_boundary = 0, gen_idle = 1;
  logic [15:0] ton_act, toff_act, ip_act, wave_act;
  logic commit_strobe, run_en, reject, stop_fault;
  logic [3:0] pending;
  int checks = 0, errors = 0;
  typedef struct {logic rej; logic com; logic [15:0] ton, toff, ip, wave;} exp_t;
  exp_t q[$];

  discharge_param_scheduler #(.STOP_TIMEOUT(20'd50)) dut (
    .clk(clk), .rst_n(rst_n),
    .change_ton_req(change_ton_req), .change_toff_req(change_toff_req),
    .change_ip_req(change_ip_req), .change_wave_req(change_wave_req),
    .ton_in(ton_in), .toff_in(toff_in), .ip_in(ip_in), .wave_in(wave_in),
    .start_req_spi(start_req_spi), .stop_req_spi(stop_req_spi),
    .start_req_key(start_req_key), .stop_req_key(stop_req_key),
    .pulse_boundary(pulse_boundary), .gen_idle(gen_idle),
    .ton_act(ton_act), .toff_act(toff_act), .ip_act(ip_act), .wave_act(wave_act),
    .commit_strobe(commit_strobe), .run_en(run_en), .pending(pending),
    .reject(reject), .stop_fault(stop_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic rej, input logic com, input logic [15:0] t, input logic [15:0] f,
                      input logic [15:0] i, input logic [15:0] w);
    exp_t e;
    e.rej = rej; e.com = com; e.ton = t; e.toff = f; e.ip = i; e.wave = w;
    q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && (commit_strobe || reject)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got rej=%0b com=%0b expected none", reject, commit_strobe);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("event", {reject, commit_strobe, ton_act, toff_act, ip_act, wave_act},
            {e.rej, e.com, e.ton, e.toff, e.ip, e.wave});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    cyc(3);
    chk("rst_act", {ton_act, toff_act, ip_act, wave_act}, {16'd100, 16'd400, 16'd0, 16'd0});
    chk("rst_ctl", {run_en, pending, commit_strobe, reject, stop_fault}, 8'd0);
    rst_n = 1;
    cyc(1);
    // stopped commit of ton
    change_ton_req = 1; ton_in = 200; push(0, 1, 200, 400, 0, 0);
    cyc(1); change_ton_req = 0;
    chk("pend_ton", pending, 4'b0001);
    cyc(1);
    chk("pend_clr", pending, 4'b0000);
    chk("ton_200", ton_act, 200);
    cyc(1);
    // validation
    change_ip_req = 1; ip_in = 4001; push(1, 0, 200, 400, 0, 0);
    cyc(1); change_ip_req = 0;
    chk("ip_rej_pend", pending, 4'b0000);
    cyc(2);
    chk("ip_rej_act", ip_act, 0);
    change_ton_req = 1; ton_in = 9; change_ip_req = 1; ip_in = 4000;
    push(1, 0, 200, 400, 0, 0); push(0, 1, 200, 400, 4000, 0);
    cyc(1); change_ton_req = 0; change_ip_req = 0;
    cyc(2);
    chk("ton9_ip4000", {ton_act, ip_act}, {16'd200, 16'd4000});
    change_toff_req = 1; toff_in = 19; push(1, 0, 200, 400, 4000, 0);
    cyc(1); change_toff_req = 0;
    cyc(2);
    chk("toff19", {toff_act, 12'd0, pending}, {16'd400, 16'd0});
    // start with coincident wave change: committed by STARTING
    start_req_spi = 1; change_wave_req = 1; wave_in = 5; push(0, 1, 200, 400, 4000, 5);
    cyc(1); start_req_spi = 0; change_wave_req = 0;
    chk("starting_run_en", run_en, 0);
    cyc(1);
    chk("running_run_en", run_en, 1);
    // toff change while running waits for boundary
    change_toff_req = 1; toff_in = 500;
    cyc(1); change_toff_req = 0;
    cyc(30);
    chk("toff_hold", {toff_act, pending}, {16'd400, 4'b0010});
    pulse_boundary = 1; push(0, 1, 200, 500, 4000, 5);
    cyc(1); pulse_boundary = 0;
    chk("toff_500", {toff_act, pending}, {16'd500, 4'b0000});
    // wave stays pending while running
    change_wave_req = 1; wave_in = 3;
    cyc(1); change_wave_req = 0;
    chk("wave_pend", pending, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      cyc(5); pulse_boundary = 1;
      cyc(1); pulse_boundary = 0;
      chk("wave_hold", {wave_act, pending}, {16'd5, 4'b1000});
    end
    // boundary coincident with a new ton write
    change_ton_req = 1; ton_in = 150;
    cyc(1); change_ton_req = 0;
    cyc(2);
    chk("ton150_pend", pending, 4'b1001);
    pulse_boundary = 1; change_ton_req = 1; ton_in = 300; push(0, 1, 150, 500, 4000, 5);
    cyc(1); pulse_boundary = 0; change_ton_req = 0;
    chk("coincident", {ton_act, pending}, {16'd150, 4'b1001});
    // stop: no commits until the generator is idle
    gen_idle = 0; stop_req_key = 1;
    cyc(1); stop_req_key = 0;
    chk("stopping_run_en", run_en, 0);
    cyc(5); start_req_spi = 1; pulse_boundary = 1;
    cyc(1); start_req_spi = 0; pulse_boundary = 0;
    cyc(20);
    chk("stopping_hold", {run_en, stop_fault, pending, ton_act}, {1'b0, 1'b0, 4'b1001, 16'd150});
    gen_idle = 1; push(0, 1, 300, 500, 4000, 3);
    cyc(3);
    chk("stopped_commit", {run_en, pending, wave_act}, {1'b0, 4'b0000, 16'd3});
    // stop beats start
    start_req_key = 1; stop_req_spi = 1;
    cyc(1); start_req_key = 0; stop_req_spi = 0;
    cyc(4);
    chk("stop_beats_start", run_en, 0);
    change_ton_req = 1; ton_in = 250; push(0, 1, 250, 500, 4000, 3);
    cyc(1); change_ton_req = 0;
    cyc(2);
    chk("still_stopped", ton_act, 250);
    // stop during STARTING
    start_req_spi = 1;
    cyc(1); start_req_spi = 0; stop_req_spi = 1;
    cyc(1); stop_req_spi = 0;
    cyc(3);
    chk("abort_start", run_en, 0);
    start_req_key = 1;
    cyc(1); start_req_key = 0;
    cyc(1);
    chk("restart", run_en, 1);
`ifdef SCHED_STOP_WATCHDOG_EN
    gen_idle = 0; stop_req_spi = 1;
    cyc(1); stop_req_spi = 0;
    n = 1;
    while (!stop_fault && n < 200) begin
      cyc(1);
      n++;
    end
    chk("wd_cycles", n, 51);
    cyc(5);
    chk("wd_sticky", stop_fault, 1);
    start_req_spi = 1; gen_idle = 1;
    cyc(1); start_req_spi = 0;
    chk("wd_clear", stop_fault, 0);
    cyc(1);
    chk("wd_restart", run_en, 1);
`else
    gen_idle = 0; stop_req_spi = 1;
    cyc(1); stop_req_spi = 0;
    cyc(200);
    chk("no_wd", {run_en, stop_fault}, 2'b00);
    start_req_spi = 1;
    cyc(1); start_req_spi = 0;
    cyc(2);
    chk("no_wd_wait", run_en, 0);
    gen_idle = 1;
    cyc(2);
    start_req_spi = 1;
    cyc(1); start_req_spi = 0;
    cyc(1);
    chk("no_wd_restart", run_en, 1);
`endif
    cyc(3);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
